// File: rtl/stall_flush_pipeline_regs_if.sv
// rtl/stall_flush_pipeline_regs_if.sv - hazard-control and pipeline-register bundle
interface stall_flush_pipeline_regs_if;
    logic        PCWriteEnable;
    logic        IFIDWriteEnable;
    logic        IDEXFlush;
    logic        Branch;
    logic [31:0] BranchTarget;
    logic [31:0] IFInstruction;
    logic [15:0] IDControl;
    logic [31:0] PC;
    logic [31:0] IDInstruction;
    logic [31:0] IDPCPlus4;
    logic [31:0] EXInstruction;
    logic [31:0] EXPCPlus4;
    logic [15:0] EXControl;
    logic [15:0] StallCount;
    logic [15:0] FlushCount;
    logic        StallActive;
    logic        LongStall;
    logic        ProtocolError;

    // Hazard unit / fetch side drives control and instruction inputs.
    modport master (
        output PCWriteEnable, IFIDWriteEnable, IDEXFlush, Branch,
        output BranchTarget, IFInstruction, IDControl,
        input  PC, IDInstruction, IDPCPlus4, EXInstruction, EXPCPlus4, EXControl,
        input  StallCount, FlushCount, StallActive, LongStall, ProtocolError
    );

    // Pipeline register block.
    modport slave (
        input  PCWriteEnable, IFIDWriteEnable, IDEXFlush, Branch,
        input  BranchTarget, IFInstruction, IDControl,
        output PC, IDInstruction, IDPCPlus4, EXInstruction, EXPCPlus4, EXControl,
        output StallCount, FlushCount, StallActive, LongStall, ProtocolError
    );
endinterface

// File: rtl/stall_flush_pipeline_regs.sv
// rtl/stall_flush_pipeline_regs.sv - PC, IF/ID, ID/EX registers with stall/flush control and stall monitor
module stall_flush_pipeline_regs (
    input  logic                         Clk,
    input  logic                         Reset,
    stall_flush_pipeline_regs_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HUNG  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  consec_stall;
    logic [2:0]  consec_next;
    logic [31:0] pc_plus4;

    // Wraps naturally at 2^32.
    assign pc_plus4 = bus.PC + 32'd4;

    // PC and IF/ID: a closed PC write gate also blocks a branch redirect.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.PC            <= 32'd0;
            bus.IDInstruction <= 32'd0;
            bus.IDPCPlus4     <= 32'd0;
        end else begin
            if (bus.PCWriteEnable) begin
                bus.PC <= bus.Branch ? bus.BranchTarget : pc_plus4;
            end
            if (bus.IFIDWriteEnable) begin
                if (bus.Branch) begin
                    bus.IDInstruction <= 32'd0;
                    bus.IDPCPlus4     <= 32'd0;
                end else begin
                    bus.IDInstruction <= bus.IFInstruction;
                    bus.IDPCPlus4     <= pc_plus4;
                end
            end
        end
    end

    // ID/EX: flush inserts a bubble regardless of the front-end enables.
    always_ff @(posedge Clk) begin
        if (Reset || bus.IDEXFlush) begin
            bus.EXInstruction <= 32'd0;
            bus.EXPCPlus4     <= 32'd0;
            bus.EXControl     <= 16'd0;
        end else begin
            bus.EXInstruction <= bus.IDInstruction;
            bus.EXPCPlus4     <= bus.IDPCPlus4;
            bus.EXControl     <= bus.IDControl;
        end
    end

    // Saturating stall and redirect counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.StallCount <= 16'd0;
            bus.FlushCount <= 16'd0;
        end else begin
            if (!bus.PCWriteEnable && bus.StallCount != 16'hFFFF) begin
                bus.StallCount <= bus.StallCount + 16'd1;
            end
            if (bus.PCWriteEnable && bus.Branch && bus.FlushCount != 16'hFFFF) begin
                bus.FlushCount <= bus.FlushCount + 16'd1;
            end
        end
    end

    // Stall monitor state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= RUN;
            consec_stall <= 3'd0;
        end else begin
            state        <= state_next;
            consec_stall <= consec_next;
        end
    end

    // Stall monitor next-state: four consecutive stalled cycles mean HUNG.
    always_comb begin
        state_next  = state;
        consec_next = consec_stall;
        case (state)
            RUN: begin
                if (!bus.PCWriteEnable) begin
                    state_next  = STALL;
                    consec_next = 3'd1;
                end
            end
            STALL: begin
                if (bus.PCWriteEnable) begin
                    state_next  = RUN;
                    consec_next = 3'd0;
                end else if (consec_stall == 3'd3) begin
                    state_next  = HUNG;
                    consec_next = 3'd4;
                end else begin
                    consec_next = consec_stall + 3'd1;
                end
            end
            HUNG: begin
                if (bus.PCWriteEnable) begin
                    state_next  = RUN;
                    consec_next = 3'd0;
                end
            end
            default: begin
                state_next  = RUN;
                consec_next = 3'd0;
            end
        endcase
    end

    // Registered status flags; LongStall and ProtocolError are sticky until reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.StallActive   <= 1'b0;
            bus.LongStall     <= 1'b0;
            bus.ProtocolError <= 1'b0;
        end else begin
            bus.StallActive <= (state_next != RUN);
            if (state_next == HUNG && state != HUNG) begin
                bus.LongStall <= 1'b1;
            end
            if (bus.PCWriteEnable != bus.IFIDWriteEnable) begin
                bus.ProtocolError <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stall_flush_pipeline_regs.sv
// tb/tb_stall_flush_pipeline_regs.sv - directed self-checking bench for stall_flush_pipeline_regs
module tb_stall_flush_pipeline_regs;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    stall_flush_pipeline_regs_if bus ();

    stall_flush_pipeline_regs dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pcwe, input logic ifidwe, input logic flush,
                         input logic br, input logic [31:0] tgt);
        bus.PCWriteEnable   = pcwe;
        bus.IFIDWriteEnable = ifidwe;
        bus.IDEXFlush       = flush;
        bus.Branch          = br;
        bus.BranchTarget    = tgt;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        bus.IFInstruction = 32'h8C010000;
        bus.IDControl     = 16'h1234;

        // Reset state
        step();
        check("rst_pc", bus.PC, 32'd0);
        check("rst_id_instr", bus.IDInstruction, 32'd0);
        check("rst_ex_ctrl", {16'd0, bus.EXControl}, 32'd0);
        check("rst_stall_cnt", {16'd0, bus.StallCount}, 32'd0);
        check("rst_flags", {29'd0, bus.StallActive, bus.LongStall, bus.ProtocolError}, 32'd0);

        // Free run three edges
        reset = 1'b0;
        step();
        check("first_fetch_pc", bus.PC, 32'h4);
        step();
        step();
        check("free_pc", bus.PC, 32'hC);
        check("free_id_instr", bus.IDInstruction, 32'h8C010000);
        check("free_id_pc4", bus.IDPCPlus4, 32'hC);
        check("free_ex_pc4", bus.EXPCPlus4, 32'h8);
        check("free_ex_ctrl", {16'd0, bus.EXControl}, 32'h1234);
        check("free_stall_cnt", {16'd0, bus.StallCount}, 32'd0);
        step();
        check("pc_0x10", bus.PC, 32'h10);

        // Load-use stall with ID/EX bubble
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        bus.IFInstruction = 32'hDEADBEEF;
        step();
        check("lu_pc", bus.PC, 32'h10);
        check("lu_id_instr", bus.IDInstruction, 32'h8C010000);
        check("lu_id_pc4", bus.IDPCPlus4, 32'h10);
        check("lu_ex_instr", bus.EXInstruction, 32'd0);
        check("lu_ex_ctrl", {16'd0, bus.EXControl}, 32'd0);
        check("lu_stall_cnt", {16'd0, bus.StallCount}, 32'd1);
        check("lu_stall_active", {31'd0, bus.StallActive}, 32'd1);

        // Flush while fetch advances
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        step();
        check("fl_pc", bus.PC, 32'h14);
        check("fl_id_instr", bus.IDInstruction, 32'hDEADBEEF);
        check("fl_ex_instr", bus.EXInstruction, 32'd0);
        check("fl_stall_active", {31'd0, bus.StallActive}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        step();
        step();
        step();
        check("pc_0x20", bus.PC, 32'h20);

        // Taken branch
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
        step();
        check("br_pc", bus.PC, 32'h100);
        check("br_id_instr", bus.IDInstruction, 32'd0);
        check("br_id_pc4", bus.IDPCPlus4, 32'd0);
        check("br_ex_instr", bus.EXInstruction, 32'hDEADBEEF);
        check("br_flush_cnt", {16'd0, bus.FlushCount}, 32'd1);

        // Branch ignored while PC write is gated
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
        step();
        check("brst_pc", bus.PC, 32'h100);
        check("brst_flush_cnt", {16'd0, bus.FlushCount}, 32'd1);
        check("brst_stall_cnt", {16'd0, bus.StallCount}, 32'd2);
        check("brst_perr", {31'd0, bus.ProtocolError}, 32'd0);

        // Long stall into HUNG and back
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        step();
        step();
        check("ls3_long", {31'd0, bus.LongStall}, 32'd0);
        check("ls3_active", {31'd0, bus.StallActive}, 32'd1);
        step();
        check("ls4_long", {31'd0, bus.LongStall}, 32'd1);
        step();
        check("ls5_stall_cnt", {16'd0, bus.StallCount}, 32'd5);
        check("ls5_pc", bus.PC, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        step();
        check("lsr_pc", bus.PC, 32'h4);
        check("lsr_active", {31'd0, bus.StallActive}, 32'd0);
        check("lsr_long_sticky", {31'd0, bus.LongStall}, 32'd1);

        // Reset while HUNG, with branch and stall requests present
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        step();
        step();
        step();
        check("hung_long", {31'd0, bus.LongStall}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h300);
        reset = 1'b1;
        step();
        check("hrst_pc", bus.PC, 32'd0);
        check("hrst_id", bus.IDInstruction | bus.IDPCPlus4, 32'd0);
        check("hrst_ex", bus.EXInstruction | bus.EXPCPlus4, 32'd0);
        check("hrst_cnts", {bus.StallCount, bus.FlushCount}, 32'd0);
        check("hrst_flags", {29'd0, bus.StallActive, bus.LongStall, bus.ProtocolError}, 32'd0);
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        step();
        check("hrst_resume_pc", bus.PC, 32'h4);
        check("hrst_resume_active", {31'd0, bus.StallActive}, 32'd0);

        // PC wrap at the top of the address space
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFC);
        step();
        check("wrap_pre_pc", bus.PC, 32'hFFFFFFFC);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        step();
        check("wrap_pc", bus.PC, 32'd0);
        check("wrap_id_pc4", bus.IDPCPlus4, 32'd0);

        // StallCount saturation
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 65535; i++) begin
            step();
        end
        check("sat_reach", {16'd0, bus.StallCount}, 32'hFFFF);
        step();
        check("sat_hold", {16'd0, bus.StallCount}, 32'hFFFF);
        check("sat_pc_held", bus.PC, 32'd0);

        // Enable mismatch raises ProtocolError but datapath still obeys enables
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.IFInstruction = 32'hCAFEF00D;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        check("perr_set", {31'd0, bus.ProtocolError}, 32'd1);
        check("perr_pc", bus.PC, 32'h4);
        check("perr_id_held", bus.IDInstruction, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        step();
        check("perr_sticky", {31'd0, bus.ProtocolError}, 32'd1);
        check("perr_id_load", bus.IDInstruction, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
